// File: rtl/dcm_ps_pkg.sv
// Shared types and constants for the DCM phase-shift responder.
package dcm_ps_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } ps_state_e;

  localparam int PS_STAT_OVF  = 0;
  localparam int PS_STAT_BUSY = 1;

  localparam logic [7:0] PS_LFSR_SEED = 8'hA5;
  localparam logic [7:0] PS_LFSR_TAPS = 8'hB8;

  localparam int PHASE_W  = 9;
  localparam int PS_CNT_W = 9;

  // Right-shifting Galois step: the bit shifted out folds the taps back in.
  function automatic logic [7:0] lfsr8_next(input logic [7:0] s);
    logic [7:0] n;
    n = {1'b0, s[7:1]};
    if (s[0]) begin
      n = n ^ PS_LFSR_TAPS;
    end else begin
      n = n;
    end
    return n;
  endfunction

endpackage

// File: rtl/dcm_ps_lfsr8.sv
// 8-bit Galois LFSR with advance enable; supplies per-request latency jitter.
module dcm_ps_lfsr8
  import dcm_ps_pkg::*;
(
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic       adv_i,
  output logic [7:0] state_o
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  // Next LFSR value: step only when a request is accepted.
  always_comb begin
    lfsr_d = lfsr_q;
    if (adv_i) begin
      lfsr_d = lfsr8_next(lfsr_q);
    end else begin
      lfsr_d = lfsr_q;
    end
  end

  // LFSR register, reseeded on reset.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      lfsr_q <= PS_LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign state_o = lfsr_q;

endmodule

// File: rtl/dcm_ps_responder.sv
// Responder emulating the DCM_SP variable phase-shift port (PSEN/PSDONE/STATUS).
// Optional latency jitter is enabled by defining DCMPS_RESP_JITTER_EN.
module dcm_ps_responder #(
  parameter int PS_LATENCY = 12,
  parameter int PS_MAX     = 255
) (
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic       locked_i,
  input  logic       psen_i,
  input  logic       psincdec_i,
  output logic       psdone_o,
  output logic [7:0] status_o,
  output logic [8:0] phase_o,
  output logic       err_o
);
  import dcm_ps_pkg::*;

  localparam logic signed [PHASE_W-1:0]  PH_MAX_S = PHASE_W'(PS_MAX);
  localparam logic signed [PHASE_W-1:0]  PH_MIN_S = -PH_MAX_S;
  localparam logic        [PS_CNT_W-1:0] CNT_LOAD = PS_CNT_W'(PS_LATENCY - 2);

  ps_state_e                   state_q;
  logic [PS_CNT_W-1:0]         cnt_q;
  logic                        dir_q;
  logic                        psdone_q;
  logic                        err_q;
  logic signed [PHASE_W-1:0]   phase_q;
  logic signed [PHASE_W-1:0]   phase_d;
  logic                        accept_s;
  logic [2:0]                  extra_s;
  logic [7:0]                  status_s;

  assign accept_s = psen_i && locked_i && (state_q == IDLE);

`ifdef DCMPS_RESP_JITTER_EN
  logic [7:0] lfsr_s;

  dcm_ps_lfsr8 u_lfsr (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .adv_i     (accept_s),
    .state_o   (lfsr_s)
  );

  assign extra_s = lfsr_s[2:0];
`else
  assign extra_s = 3'd0;
`endif

  // Saturating phase step applied when the shift completes.
  always_comb begin
    phase_d = phase_q;
    if (dir_q) begin
      if (phase_q < PH_MAX_S) begin
        phase_d = phase_q + 9'sd1;
      end else begin
        phase_d = phase_q;
      end
    end else begin
      if (phase_q > PH_MIN_S) begin
        phase_d = phase_q - 9'sd1;
      end else begin
        phase_d = phase_q;
      end
    end
  end

  // Handshake FSM: IDLE -> BUSY (counted) -> DONE (pulse + phase update).
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      dir_q    <= 1'b0;
      psdone_q <= 1'b0;
      err_q    <= 1'b0;
      phase_q  <= '0;
    end else begin
      psdone_q <= 1'b0;
      if (psen_i && !accept_s) begin
        err_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (accept_s) begin
            dir_q   <= psincdec_i;
            cnt_q   <= CNT_LOAD + {{(PS_CNT_W-3){1'b0}}, extra_s};
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (cnt_q == '0) begin
            state_q  <= DONE;
            psdone_q <= 1'b1;
            phase_q  <= phase_d;
          end else begin
            cnt_q <= cnt_q - PS_CNT_W'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Status bus: limit flag from the phase register, busy from the state.
  always_comb begin
    status_s               = 8'h00;
    status_s[PS_STAT_OVF]  = (phase_q == PH_MAX_S) || (phase_q == PH_MIN_S);
    status_s[PS_STAT_BUSY] = (state_q == BUSY) || (state_q == DONE);
  end

  assign psdone_o = psdone_q;
  assign status_o = status_s;
  assign phase_o  = phase_q;
  assign err_o    = err_q;

endmodule

// File: tb/tb_dcm_ps_responder.sv
// Self-checking bench: timestamp-based reference model plus directed scenarios.
module tb_dcm_ps_responder;

  localparam int LAT   = 12;
  localparam int PSMAX = 255;

  logic       clk_i = 1'b0;
  logic       reset_n_i;
  logic       locked_i;
  logic       psen_i;
  logic       psincdec_i;
  logic       psdone_o;
  logic [7:0] status_o;
  logic [8:0] phase_o;
  logic       err_o;

  int total = 0;
  int bad   = 0;
  bit started = 1'b0;

  dcm_ps_responder #(.PS_LATENCY(LAT), .PS_MAX(PSMAX)) dut (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .locked_i   (locked_i),
    .psen_i     (psen_i),
    .psincdec_i (psincdec_i),
    .psdone_o   (psdone_o),
    .status_o   (status_o),
    .phase_o    (phase_o),
    .err_o      (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference model: tracks edge numbers at which each accepted request completes.
  int         e;
  bit         m_infl;
  bit         m_dir;
  int         m_done_e;
  int         m_idle_e;
  int         m_phase;
  bit         m_psdone;
  bit         m_busy;
  bit         m_err;
  logic [7:0] m_lf;

  always @(posedge clk_i) begin
    int lat;
    if (!reset_n_i) begin
      e = 0; m_infl = 0; m_phase = 0; m_psdone = 0; m_busy = 0; m_err = 0;
      m_lf = 8'hA5;
    end else begin
      e++;
      m_psdone = m_infl && (e == m_done_e);
      if (m_psdone) begin
        if (m_dir && m_phase < PSMAX) m_phase++;
        else if (!m_dir && m_phase > -PSMAX) m_phase--;
      end
      if (psen_i) begin
        if (locked_i && (!m_infl || e >= m_idle_e)) begin
          lat = LAT;
`ifdef DCMPS_RESP_JITTER_EN
          lat = LAT + int'(m_lf & 8'h07);
          m_lf = (m_lf >> 1) ^ (m_lf[0] ? 8'hB8 : 8'h00);
`endif
          m_infl   = 1;
          m_dir    = psincdec_i;
          m_done_e = e + lat - 1;
          m_idle_e = e + lat + 1;
        end else begin
          m_err = 1;
        end
      end
      m_busy = m_infl && (e <= m_done_e);
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk_i) begin
    int ovf;
    if (reset_n_i && started) begin
      ovf = (m_phase == PSMAX || m_phase == -PSMAX) ? 1 : 0;
      check("psdone", int'(psdone_o), int'(m_psdone));
      check("phase", 32'($signed(phase_o)), m_phase);
      check("status", int'(status_o), (int'(m_busy) << 1) | ovf);
      check("err", int'(err_o), int'(m_err));
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    reset_n_i = 1'b0; psen_i = 1'b0; psincdec_i = 1'b0; locked_i = 1'b1;
    tick(); tick();
    reset_n_i = 1'b1;
  endtask

  // One request; returns cycles to psdone and leaves the bench one cycle after it.
  task automatic shift(input bit dir, output int lat);
    int n;
    psen_i = 1'b1; psincdec_i = dir;
    tick();
    psen_i = 1'b0;
    n = 1;
    while (!psdone_o && n < 300) begin
      tick();
      n++;
    end
    if (!psdone_o) begin
      total++; bad++;
      $display("FAIL timeout: got no psdone after %0d cycles expected one", n);
    end
    lat = n;
`ifdef DCMPS_RESP_JITTER_EN
    check("lat_range", int'(lat >= LAT && lat <= LAT + 7), 1);
`else
    check("lat", lat, LAT);
`endif
    tick();
  endtask

  task automatic count_done(input int cycles, output int cnt);
    cnt = 0;
    repeat (cycles) begin
      if (psdone_o) cnt++;
      tick();
    end
  endtask

  initial begin
    int lat;
    int cnt;
    do_reset();
    started = 1'b1;
    check("rst_psdone", int'(psdone_o), 0);
    check("rst_phase", int'(phase_o), 0);
    check("rst_status", int'(status_o), 0);
    check("rst_err", int'(err_o), 0);

    // Single increment, then ramp to the positive limit and one past it.
    shift(1'b1, lat);
    check("inc1_phase", int'(phase_o), 1);
    check("inc1_status", int'(status_o), 0);
    for (int i = 0; i < 254; i++) shift(1'b1, lat);
    check("max_phase", int'(phase_o), 255);
    check("max_ovf", int'(status_o[0]), 1);
    shift(1'b1, lat);
    check("sat_phase", int'(phase_o), 255);
    check("sat_ovf", int'(status_o[0]), 1);

    // Decrement to the negative limit and one past it, then step back in.
    do_reset();
    for (int i = 0; i < 256; i++) shift(1'b0, lat);
    check("min_phase", int'(phase_o), 32'h101);
    check("min_ovf", int'(status_o[0]), 1);
    shift(1'b1, lat);
    check("m254_phase", int'(phase_o), 32'h102);
    check("m254_ovf", int'(status_o[0]), 0);

    // PSEN five cycles into BUSY.
    do_reset();
    psen_i = 1'b1; psincdec_i = 1'b1; tick(); psen_i = 1'b0;
    repeat (4) tick();
    psen_i = 1'b1; tick(); psen_i = 1'b0;
    count_done(30, cnt);
    check("busy_dones", cnt, 1);
    check("busy_phase", int'(phase_o), 1);
    check("busy_err", int'(err_o), 1);

    // PSEN while unlocked.
    do_reset();
    locked_i = 1'b0;
    psen_i = 1'b1; psincdec_i = 1'b1; tick(); psen_i = 1'b0;
    count_done(25, cnt);
    check("unlk_dones", cnt, 0);
    check("unlk_phase", int'(phase_o), 0);
    check("unlk_err", int'(err_o), 1);
    locked_i = 1'b1;

    // Lock lost mid-shift: the shift still completes.
    do_reset();
    psen_i = 1'b1; psincdec_i = 1'b0; tick(); psen_i = 1'b0;
    repeat (3) tick();
    locked_i = 1'b0;
    count_done(25, cnt);
    check("lockfall_dones", cnt, 1);
    check("lockfall_phase", 32'($signed(phase_o)), -1);
    check("lockfall_err", int'(err_o), 0);
    locked_i = 1'b1;

    // Reset six cycles after PSEN.
    do_reset();
    psen_i = 1'b1; psincdec_i = 1'b1; tick(); psen_i = 1'b0;
    repeat (5) tick();
    reset_n_i = 1'b0;
    #1;
    check("mrst_psdone", int'(psdone_o), 0);
    check("mrst_phase", int'(phase_o), 0);
    check("mrst_status", int'(status_o), 0);
    tick();
    reset_n_i = 1'b1;
    count_done(25, cnt);
    check("mrst_dones", cnt, 0);
    check("mrst_phase2", int'(phase_o), 0);
    check("mrst_status2", int'(status_o), 0);

`ifdef DCMPS_RESP_JITTER_EN
    begin
      logic [7:0] lf;
      do_reset();
      lf = 8'hA5;
      for (int i = 0; i < 100; i++) begin
        shift(1'b1, lat);
        check("jit_lat", lat, LAT + int'(lf & 8'h07));
        lf = (lf >> 1) ^ (lf[0] ? 8'hB8 : 8'h00);
      end
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
